acc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one W-bit accumulating counter datapath among NREQ requesters. Each requester posts an increment; the block grants one requester at a time, latches its increment and commits it to the shared accumulator on the following cycle. It sits in front of the counter datapath so several producers can step the same register without collisions. It carries its own immediate assertions for formal proof.

---
 rtl/acc_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 31 +++
 rtl/acc_arbiter.sv | 119 +++++++++++
 tb/tb_acc_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_arb_pkg.sv
// Shared types and sizing helpers for the round-robin accumulator arbiter.
package acc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 32;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_picker
  import acc_arb_pkg::*;
#(
  parameter int  NREQ = NREQ_DEF,
  localparam int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_next,
  output logic [IW-1:0]   k
);

  always_comb begin
    int   idx;
    logic found;
    gnt_next = '0;
    k        = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found         = 1'b1;
        k             = idx[IW-1:0];
        gnt_next[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_arbiter.sv
// Shares one W-bit accumulator among NREQ requesters: grant one, latch its
// increment, commit it on the next cycle.
module acc_arbiter
  import acc_arb_pkg::*;
#(
  parameter int  NREQ = NREQ_DEF,
  parameter int  W    = W_DEF,
  localparam int IW   = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] inc,
  input  logic            clr,
  output logic [NREQ-1:0] gnt,
  output logic [W-1:0]    acc,
  output logic            acc_vld,
  output logic [IW-1:0]   last_id,
  output logic            ovf,
  output logic [1:0]      dbg_state
);

  // Handshake: a requester holds req[i] high with a stable inc[i] until it
  // sees gnt[i]; it drops req[i] on the following cycle.

  state_t          state, state_nx;
  logic [NREQ-1:0] pick_gnt, k_mask;
  logic [IW-1:0]   pick_k, ptr, ptr_nx, k_lat;
  logic [W-1:0]    inc_sel, inc_lat;
  logic [W:0]      sum;
  logic            take;
  logic            was_commit;
  logic            all_even;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .ptr      (ptr),
    .gnt_next (pick_gnt),
    .k        (pick_k)
  );

  assign inc_sel   = inc[int'(pick_k)*W +: W];
  assign ptr_nx    = (int'(pick_k) == NREQ-1) ? '0 : pick_k + IW'(1);
  assign sum       = {1'b0, acc} + {1'b0, inc_lat};
  assign take      = (state == GRANT) && (|req) && !clr;
  assign dbg_state = state;

  always_comb begin
    k_mask        = '0;
    k_mask[k_lat] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    gnt      = '0;
    case (state)
      IDLE:    if (|req) state_nx = GRANT;
      GRANT: begin
        gnt      = pick_gnt;
        state_nx = (|req) ? COMMIT : IDLE;
      end
      // The just-granted requester may still be high this cycle; ignore it.
      COMMIT:  state_nx = (|(req & ~k_mask)) ? GRANT : IDLE;
      default: state_nx = IDLE;
    endcase
    if (clr) begin
      state_nx = IDLE;
      gnt      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      k_lat      <= '0;
      inc_lat    <= '0;
      acc        <= '0;
      acc_vld    <= 1'b0;
      last_id    <= '0;
      ovf        <= 1'b0;
      was_commit <= 1'b0;
      all_even   <= 1'b1;
    end else begin
      state      <= state_nx;
      acc_vld    <= 1'b0;
      was_commit <= (state == COMMIT);
      if (clr) begin
        acc      <= '0;
        ovf      <= 1'b0;
        last_id  <= '0;
        all_even <= 1'b1;
      end else begin
        if (take) begin
          inc_lat <= inc_sel;
          k_lat   <= pick_k;
          ptr     <= ptr_nx;
        end
        if (state == COMMIT) begin
          acc      <= sum[W-1:0];
          ovf      <= ovf | sum[W];
          last_id  <= k_lat;
          acc_vld  <= 1'b1;
          all_even <= all_even & ~inc_lat[0];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      a_gnt_onehot: assert ($onehot0(gnt));
      a_gnt_state:  assert (gnt == '0 || state == GRANT);
      a_vld_commit: assert (!acc_vld || was_commit);
      a_even_acc:   assert (!all_even || !acc[0]);
    end
  end

endmodule

// File: tb/tb_acc_arbiter.sv
// Self-checking bench for acc_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbitration and accumulation rules.
module tb_acc_arbiter;
  import acc_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] inc;
  logic           clr;
  logic [N-1:0]   gnt;
  logic [W-1:0]   acc;
  logic           acc_vld;
  logic [IW-1:0]  last_id;
  logic           ovf;
  logic [1:0]     dbg_state;

  acc_arbiter #(.NREQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .inc       (inc),
    .clr       (clr),
    .gnt       (gnt),
    .acc       (acc),
    .acc_vld   (acc_vld),
    .last_id   (last_id),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [N-1:0] hold;
  logic [N-1:0] was_low;
  logic [W-1:0] val [N];
  logic         clr_drv;

  // Reference model: slot 0 = free, 1 = choosing a winner, 2 = adding it in.
  int              slot, m_ptr, m_k, m_last;
  logic [W-1:0]    m_inc;
  logic            m_vld;
  longint unsigned total;   // sum of commits since last clear/reset

  logic [W-1:0] exp_q[$];
  int           glog[$], gcyc[$], vcyc[$];
  logic [W-1:0] vlog[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++)
      if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int k;
    g = '0;
    if (slot == 1 && !clr_drv) begin
      k = pick(req, m_ptr);
      if (k >= 0) g[k] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_edge();
    int k;
    logic [N-1:0] others;
    m_vld = 1'b0;
    if (clr_drv) begin
      total  = 0;
      m_last = 0;
      slot   = 0;
    end else if (slot == 0) begin
      if (req != 0) slot = 1;
    end else if (slot == 1) begin
      k = pick(req, m_ptr);
      if (k < 0) slot = 0;
      else begin
        m_k   = k;
        m_inc = val[k];
        m_ptr = (k + 1) % N;
        slot  = 2;
      end
    end else begin
      total  = total + longint'(m_inc);
      m_last = m_k;
      m_vld  = 1'b1;
      exp_q.push_back(total[W-1:0]);
      others       = req;
      others[m_k]  = 1'b0;
      slot = (others != 0) ? 1 : 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    req = hold;
    clr = clr_drv;
    for (int i = 0; i < N; i++) inc[i*W +: W] = val[i];
  endtask

  task automatic tick();
    logic [N-1:0] g;
    state_t es;
    apply_inputs();
    @(negedge clk);
    g  = model_gnt();
    es = (slot == 0) ? IDLE : (slot == 1) ? GRANT : COMMIT;
    check("gnt", gnt, g);
    check("acc", acc, total[W-1:0]);
    check("acc_vld", acc_vld, m_vld);
    check("last_id", last_id, m_last);
    check("ovf", ovf, total >= (64'd1 << W));
    check("state", dbg_state, es);
    if (acc_vld) begin
      if (exp_q.size() == 0) check("sb_unexpected_vld", 1, 0);
      else check("sb_acc", acc, exp_q.pop_front());
      vlog.push_back(acc);
      vcyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++)
      if (gnt[i]) begin
        glog.push_back(i);
        gcyc.push_back(cyc);
      end
    @(posedge clk);
    model_edge();
    #1;
    hold = hold & ~g;
    cyc++;
  endtask

  task automatic model_reset();
    slot = 0; m_ptr = 0; m_k = 0; m_last = 0; m_inc = '0; m_vld = 1'b0; total = 0;
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    hold = '0; was_low = '0; clr_drv = 1'b0;
    for (int i = 0; i < N; i++) val[i] = '0;
    apply_inputs();
    model_reset();
    glog.delete(); gcyc.delete(); vlog.delete(); vcyc.delete();
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_acc", acc, 0);
    check("rst_vld", acc_vld, 0);
    check("rst_last", last_id, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((hold != 0 || slot != 0) && n < maxc) begin
      tick();
      n++;
    end
    check("drain_timeout", n >= maxc, 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req = '0; inc = '0; clr = 1'b0;

    // single request: grant in cycle 1, result visible in cycle 3
    reset_dut();
    hold[2] = 1'b1; val[2] = 32'd5;
    drain(20);
    check("t1_ngnt", glog.size(), 1);
    check("t1_gid", glog[0], 2);
    check("t1_gcyc", gcyc[0], 1);
    check("t1_acc", vlog[0], 5);
    check("t1_vcyc", vcyc[0], 3);
    check("t1_last", last_id, 2);

    // all four requesting
    reset_dut();
    hold = 4'b1111;
    val[0] = 32'd2; val[1] = 32'd4; val[2] = 32'd6; val[3] = 32'd8;
    drain(40);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", glog[i], i);
      check("t2_acc", vlog[i], (i + 1) * (i + 2));
    end
    check("t2_ovf", ovf, 0);

    // wrap past 2^W, sticky overflow until clr
    reset_dut();
    hold[0] = 1'b1; val[0] = 32'hFFFF_FFFE;
    drain(20);
    hold[1] = 1'b1; val[1] = 32'd4;
    drain(20);
    check("t3_wrap_acc", acc, 32'h0000_0002);
    check("t3_wrap_ovf", ovf, 1);
    hold[2] = 1'b1; val[2] = 32'd3;
    drain(20);
    check("t3_sticky_acc", acc, 5);
    check("t3_sticky_ovf", ovf, 1);
    clr_drv = 1'b1; tick(); clr_drv = 1'b0; tick();
    check("t3_clr_acc", acc, 0);
    check("t3_clr_ovf", ovf, 0);

    // fairness: requesters 0 and 3 re-raise one cycle after each grant
    reset_dut();
    hold[0] = 1'b1; hold[3] = 1'b1; val[0] = 32'd1; val[3] = 32'd2;
    for (int c = 0; c < 24; c++) begin
      tick();
      for (int i = 0; i < N; i += 3)
        if (!hold[i]) begin
          if (was_low[i]) begin hold[i] = 1'b1; was_low[i] = 1'b0; end
          else was_low[i] = 1'b1;
        end
    end
    drain(20);
    check("t4_ngnt", glog.size() >= 8, 1);
    for (int i = 0; i < 8; i++) check("t4_alt", glog[i], (i % 2) ? 3 : 0);

    // clr during COMMIT discards the latched increment
    reset_dut();
    hold[0] = 1'b1; val[0] = 32'd10;
    drain(20);
    hold[1] = 1'b1; val[1] = 32'd7; hold[2] = 1'b1; val[2] = 32'd3;
    for (int c = 0; c < 10 && slot != 2; c++) tick();
    check("t5_in_commit", slot, 2);
    check("t5_pre_acc", acc, 10);
    clr_drv = 1'b1; tick(); clr_drv = 1'b0;
    check("t5_acc", acc, 0);
    check("t5_vld", acc_vld, 0);
    check("t5_state", dbg_state, IDLE);
    drain(20);
    check("t5_regrant", glog[glog.size()-1], 2);
    check("t5_final_acc", acc, 3);
    check("t5_final_last", last_id, 2);

    // async reset in the middle of a GRANT cycle
    reset_dut();
    hold[0] = 1'b1; val[0] = 32'hFFFF_FFFF;
    drain(20);
    hold[0] = 1'b1; val[0] = 32'd3;
    drain(20);
    check("t6_pre_ovf", ovf, 1);
    hold[1] = 1'b1; val[1] = 32'd9;
    tick();
    apply_inputs();
    #2;
    check("t6_gnt_live", gnt, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("t6_gnt", gnt, 0);
    check("t6_acc", acc, 0);
    check("t6_ovf", ovf, 0);
    check("t6_state", dbg_state, IDLE);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    drain(20);
    check("t6_acc_after", acc, 9);
    check("t6_last_after", last_id, 1);

    // random traffic with occasional clears
    reset_dut();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (!hold[i]) begin
          if (was_low[i] && $urandom_range(0, 2) == 0) begin
            hold[i]    = 1'b1;
            was_low[i] = 1'b0;
            case ($urandom_range(0, 3))
              0:       val[i] = '0;
              1:       val[i] = W'($urandom_range(0, 15));
              default: val[i] = $urandom;
            endcase
          end else begin
            was_low[i] = 1'b1;
            val[i]     = $urandom;
          end
        end
      clr_drv = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr_drv = 1'b0;
    drain(100);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
